// File: rtl/ky32_ctrl_if.sv
// Shared instruction/data memory handshake between the KY32 control FSM and the memory port.
interface ky32_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/ky32_ctrl.sv
// KY32 multi-cycle main control FSM: Moore outputs decoded from a 4-bit state register.
// Optional macro KY32_ILLEGAL_TRAP_EN: illegal instructions park the FSM in HALT instead of retiring as NOPs.
module ky32_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    ky32_ctrl_if.master mem,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zr,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_srca,
    output logic [1:0]  alu_srcb,
    output logic        imm_zx,
    output logic [3:0]  alu_c,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic [31:0] instret,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam state_t RESET_STATE = S_FETCH;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_instret;

    logic        w_op_r;
    logic        w_r_legal;
    logic        w_i_legal;
    logic        w_is_mem;
    logic        w_is_br;
    logic        w_is_j;

    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_iord;
    logic        w_ir_we;
    logic        w_pc_we;
    logic [1:0]  w_pc_src;
    logic        w_srca;
    logic [1:0]  w_srcb;
    logic        w_imm_zx;
    logic [3:0]  w_alu_c;
    logic        w_reg_we;
    logic        w_reg_dst;
    logic        w_mem_to_reg;
    logic        w_retire;
    logic        w_halted;

    assign w_op_r    = (opcode == OP_RTYPE);
    assign w_r_legal = w_op_r && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03});
    assign w_i_legal = opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    assign w_is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
    assign w_is_br   = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign w_is_j    = (opcode == OP_J);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET_STATE;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = 2'b00;
        w_srca       = 1'b0;
        w_srcb       = 2'b00;
        w_imm_zx     = 1'b0;
        w_alu_c      = ALU_ADD;
        w_reg_we     = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_retire     = 1'b0;
        w_halted     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_srcb    = 2'b01;
                if (mem.mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_pc_we      = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target (PC+4 + imm<<2) is parked in ALUOut here for BRANCH to use.
                w_srcb = 2'b11;
                if (w_is_mem) begin
                    w_state_next = S_MEMADR;
                end else if (w_r_legal || w_i_legal) begin
                    w_state_next = S_EXEC;
                end else if (w_is_br) begin
                    w_state_next = S_BRANCH;
                end else if (w_is_j) begin
                    w_state_next = S_JUMP;
                end else begin
`ifdef KY32_ILLEGAL_TRAP_EN
                    w_state_next = S_HALT;
`else
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
`endif
                end
            end
            S_MEMADR: begin
                w_srca       = 1'b1;
                w_srcb       = 2'b10;
                w_state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (mem.mem_ready) begin
                    w_state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_reg_we     = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
                if (mem.mem_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                w_srca       = 1'b1;
                w_state_next = S_ALUWB;
                if (w_op_r) begin
                    w_srcb = 2'b00;
                    case (funct)
                        6'h22:   w_alu_c = ALU_SUB;
                        6'h24:   w_alu_c = ALU_AND;
                        6'h25:   w_alu_c = ALU_OR;
                        6'h26:   w_alu_c = ALU_XOR;
                        6'h00:   w_alu_c = ALU_SLL;
                        6'h02:   w_alu_c = ALU_SRL;
                        6'h03:   w_alu_c = ALU_SRA;
                        default: w_alu_c = ALU_ADD;
                    endcase
                end else begin
                    w_srcb = 2'b10;
                    case (opcode)
                        OP_ANDI: begin w_alu_c = ALU_AND; w_imm_zx = 1'b1; end
                        OP_ORI:  begin w_alu_c = ALU_OR;  w_imm_zx = 1'b1; end
                        OP_XORI: begin w_alu_c = ALU_XOR; w_imm_zx = 1'b1; end
                        OP_LUI:  w_alu_c = ALU_LUI;
                        default: w_alu_c = ALU_ADD;
                    endcase
                end
            end
            S_ALUWB: begin
                w_reg_we     = 1'b1;
                w_reg_dst    = w_op_r;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                w_srca       = 1'b1;
                w_alu_c      = ALU_SUB;
                w_pc_src     = 2'b01;
                w_pc_we      = ((opcode == OP_BEQ) && alu_zr) || ((opcode == OP_BNE) && !alu_zr);
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                w_pc_we      = 1'b1;
                w_pc_src     = 2'b10;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
`ifdef KY32_ILLEGAL_TRAP_EN
            S_HALT: begin
                w_halted     = 1'b1;
                w_state_next = S_HALT;
            end
`endif
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // Outputs are gated by rst_n so an in-flight memory request drops the moment reset asserts.
    assign mem.mem_req = rst_n & w_mem_req;
    assign mem.mem_we  = rst_n & w_mem_we;
    assign mem.iord    = rst_n & w_iord;
    assign ir_we       = rst_n & w_ir_we;
    assign pc_we       = rst_n & w_pc_we;
    assign pc_src      = rst_n ? w_pc_src : 2'b00;
    assign alu_srca    = rst_n & w_srca;
    assign alu_srcb    = rst_n ? w_srcb : 2'b00;
    assign imm_zx      = rst_n & w_imm_zx;
    assign alu_c       = rst_n ? w_alu_c : 4'b0000;
    assign reg_we      = rst_n & w_reg_we;
    assign reg_dst     = rst_n & w_reg_dst;
    assign mem_to_reg  = rst_n & w_mem_to_reg;
    assign instr_done  = rst_n & w_retire;
    assign instret     = r_instret;
`ifdef KY32_ILLEGAL_TRAP_EN
    assign halted      = rst_n & w_halted;
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_ky32_ctrl.sv
// Self-checking bench for ky32_ctrl: directed vector table, hand-written corner sequences, random instruction stream.
`timescale 1ns/1ps
module tb_ky32_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        alu_zr = 1'b0;
    logic        ir_we, pc_we, alu_srca, imm_zx, reg_we, reg_dst, mem_to_reg, instr_done, halted;
    logic [1:0]  pc_src, alu_srcb;
    logic [3:0]  alu_c;
    logic [31:0] instret;

    ky32_ctrl_if mem_bus();

    always #5 clk = ~clk;

    ky32_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mem(mem_bus),
        .opcode(opcode), .funct(funct), .alu_zr(alu_zr),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .imm_zx(imm_zx), .alu_c(alu_c),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .instret(instret), .halted(halted)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic       imm_zx;
        logic [3:0] alu_c;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zr;
        int         len;
        logic [3:0] alu;
        logic [1:0] srcb;
        logic       zx;
        logic       pcwe;
        logic       rdst;
    } vec_t;

    typedef enum int {K_ILL, K_LW, K_SW, K_R, K_I, K_B, K_J} kind_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_instret = 32'd0;
    ctl_t        trace[$];
    ctl_t        exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s.mem_req    = mem_bus.mem_req;
        s.mem_we     = mem_bus.mem_we;
        s.iord       = mem_bus.iord;
        s.ir_we      = ir_we;
        s.pc_we      = pc_we;
        s.pc_src     = pc_src;
        s.alu_srca   = alu_srca;
        s.alu_srcb   = alu_srcb;
        s.imm_zx     = imm_zx;
        s.alu_c      = alu_c;
        s.reg_we     = reg_we;
        s.reg_dst    = reg_dst;
        s.mem_to_reg = mem_to_reg;
        s.instr_done = instr_done;
        s.halted     = halted;
        return s;
    endfunction

    // Reference model: instruction class -> the list of per-cycle control words it should produce.
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                      return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03}) ? K_R : K_ILL;
            6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_I;
            6'h23:                      return K_LW;
            6'h2B:                      return K_SW;
            6'h04, 6'h05:               return K_B;
            6'h02:                      return K_J;
            default:                    return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        string m;
        if (op == 6'h00) begin
            case (fn)
                6'h22: m = "sub"; 6'h24: m = "and"; 6'h25: m = "or";  6'h26: m = "xor";
                6'h00: m = "sll"; 6'h02: m = "srl"; 6'h03: m = "sra"; default: m = "add";
            endcase
        end else begin
            case (op)
                6'h0C: m = "and"; 6'h0D: m = "or"; 6'h0E: m = "xor"; 6'h0F: m = "lui"; default: m = "add";
            endcase
        end
        case (m)
            "sub": return 4'b0100; "and": return 4'b0001; "or":  return 4'b0101;
            "xor": return 4'b0010; "lui": return 4'b0110; "sll": return 4'b0011;
            "srl": return 4'b0111; "sra": return 4'b1111; default: return 4'b0000;
        endcase
    endfunction

    function automatic void build_expect(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                                         input int wf, input int wm);
        ctl_t  c;
        kind_t k;
        k = classify(op, fn);
        exp_q.delete();
        c = '0; c.mem_req = 1'b1; c.alu_srcb = 2'b01;
        repeat (wf) exp_q.push_back(c);
        c.ir_we = 1'b1; c.pc_we = 1'b1;
        exp_q.push_back(c);
        c = '0; c.alu_srcb = 2'b11;
        if (k == K_ILL) begin
`ifdef KY32_ILLEGAL_TRAP_EN
            exp_q.push_back(c);
            c = '0; c.halted = 1'b1;
            exp_q.push_back(c);
`else
            c.instr_done = 1'b1;
            exp_q.push_back(c);
`endif
            return;
        end
        exp_q.push_back(c);
        case (k)
            K_LW, K_SW: begin
                c = '0; c.alu_srca = 1'b1; c.alu_srcb = 2'b10;
                exp_q.push_back(c);
                c = '0; c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = (k == K_SW);
                repeat (wm) exp_q.push_back(c);
                c.instr_done = (k == K_SW);
                exp_q.push_back(c);
                if (k == K_LW) begin
                    c = '0; c.reg_we = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
                    exp_q.push_back(c);
                end
            end
            K_R, K_I: begin
                c = '0; c.alu_srca = 1'b1; c.alu_srcb = (k == K_R) ? 2'b00 : 2'b10;
                c.alu_c = alu_of(op, fn);
                c.imm_zx = (k == K_I) && (op inside {6'h0C, 6'h0D, 6'h0E});
                exp_q.push_back(c);
                c = '0; c.reg_we = 1'b1; c.reg_dst = (k == K_R); c.instr_done = 1'b1;
                exp_q.push_back(c);
            end
            K_B: begin
                c = '0; c.alu_srca = 1'b1; c.alu_c = 4'b0100; c.pc_src = 2'b01; c.instr_done = 1'b1;
                c.pc_we = (op == 6'h04) ? zr : !zr;
                exp_q.push_back(c);
            end
            default: begin
                c = '0; c.pc_we = 1'b1; c.pc_src = 2'b10; c.instr_done = 1'b1;
                exp_q.push_back(c);
            end
        endcase
    endfunction

    function automatic logic counts(input logic [5:0] op, input logic [5:0] fn);
`ifdef KY32_ILLEGAL_TRAP_EN
        return classify(op, fn) != K_ILL;
`else
        return 1'b1;
`endif
    endfunction

    // Runs one instruction from FETCH, holding mem_ready low for wf/wm cycles of each memory request.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                             input int wf, input int wm);
        int   cf, cm;
        bit   done;
        ctl_t s;
        trace.delete();
        cf = wf; cm = wm; done = 0;
        @(negedge clk);
        check("instret_at_fetch", instret, model_instret);
        opcode = op; funct = fn; alu_zr = zr;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_bus.mem_ready = 1'b0;
            #1;
            if (mem_bus.mem_req) begin
                if (!mem_bus.iord) begin
                    if (cf > 0) cf--; else mem_bus.mem_ready = 1'b1;
                end else begin
                    if (cm > 0) cm--; else mem_bus.mem_ready = 1'b1;
                end
            end else begin
                mem_bus.mem_ready = 1'b1;
            end
            #1;
            s = sample();
            trace.push_back(s);
            if (s.instr_done || s.halted) begin
                done = 1;
                break;
            end
        end
        if (!done) check("retire_timeout", 32'd0, 32'd1);
        if (counts(op, fn)) model_instret = model_instret + 32'd1;
    endtask

    task automatic compare_trace(input string tag);
        check({tag, "_len"}, trace.size(), exp_q.size());
        for (int i = 0; i < trace.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), 32'(trace[i]), 32'(exp_q[i]));
        end
        $display("[TB] %s op=%h fn=%h cycles=%0d instret_model=%0d", tag, opcode, funct, trace.size(), model_instret);
    endtask

    vec_t tbl[20];

    initial begin
        ctl_t s;
        int   n_mem;
        logic [5:0] rop, rfn;
        logic       rzr;

        tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{6'h00, 6'h22, 1'b0, 4, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{6'h00, 6'h24, 1'b0, 4, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{6'h00, 6'h25, 1'b0, 4, 4'b0101, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{6'h00, 6'h26, 1'b0, 4, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{6'h00, 6'h00, 1'b0, 4, 4'b0011, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{6'h00, 6'h02, 1'b0, 4, 4'b0111, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{6'h00, 6'h03, 1'b0, 4, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{6'h08, 6'h11, 1'b0, 4, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{6'h0C, 6'h00, 1'b0, 4, 4'b0001, 2'b10, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{6'h0D, 6'h20, 1'b0, 4, 4'b0101, 2'b10, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{6'h0E, 6'h03, 1'b0, 4, 4'b0010, 2'b10, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{6'h0F, 6'h00, 1'b0, 4, 4'b0110, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{6'h23, 6'h00, 1'b0, 5, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{6'h2B, 6'h00, 1'b0, 4, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{6'h04, 6'h00, 1'b1, 3, 4'b0100, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{6'h04, 6'h00, 1'b0, 3, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{6'h05, 6'h00, 1'b1, 3, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{6'h05, 6'h00, 1'b0, 3, 4'b0100, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{6'h02, 6'h00, 1'b0, 3, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0};

        // Reset: every output low even though the state register sits in FETCH.
        mem_bus.mem_ready = 1'b1;
        #1;
        check("reset_outputs", 32'(sample()), 32'd0);
        check("reset_instret", instret, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_clocked", 32'(sample()), 32'd0);
        mem_bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_reset_mem_req", mem_bus.mem_req, 1'b1);
        check("post_reset_iord", mem_bus.iord, 1'b0);

        // Directed table, no wait states.
        for (int i = 0; i < 20; i++) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].zr, 0, 0);
            check($sformatf("tbl%0d_len", i), trace.size(), tbl[i].len);
            if (trace.size() >= 3) begin
                check($sformatf("tbl%0d_alu_c", i), trace[2].alu_c, tbl[i].alu);
                check($sformatf("tbl%0d_srcb", i), trace[2].alu_srcb, tbl[i].srcb);
                check($sformatf("tbl%0d_imm_zx", i), trace[2].imm_zx, tbl[i].zx);
            end
            check($sformatf("tbl%0d_pc_we_last", i), trace[trace.size()-1].pc_we, tbl[i].pcwe);
            check($sformatf("tbl%0d_reg_dst_last", i), trace[trace.size()-1].reg_dst, tbl[i].rdst);
            $display("[TB] vector %0d op=%h fn=%h cycles=%0d", i, tbl[i].op, tbl[i].fn, trace.size());
        end

        // lw with three wait cycles in MEMRD.
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
        check("lw_wait_len", trace.size(), 8);
        n_mem = 0;
        foreach (trace[i]) if (trace[i].mem_req && trace[i].iord) n_mem++;
        check("lw_wait_req_cycles", n_mem, 4);
        check("lw_wait_mem_to_reg", trace[trace.size()-1].mem_to_reg, 1'b1);
        build_expect(6'h23, 6'h00, 1'b0, 0, 3);
        compare_trace("lw_wait");

        // Illegal opcode 0x3F.
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
`ifdef KY32_ILLEGAL_TRAP_EN
        check("illegal_len", trace.size(), 3);
        check("illegal_halted", trace[trace.size()-1].halted, 1'b1);
        check("illegal_no_req", trace[trace.size()-1].mem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_stays", halted, 1'b1);
            check("halt_no_done", instr_done, 1'b0);
            check("halt_instret", instret, model_instret);
        end
        rst_n = 1'b0;
        mem_bus.mem_ready = 1'b0;
        #1;
        check("halt_reset_clears", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_instret = 32'd0;
`else
        check("illegal_len", trace.size(), 2);
        check("illegal_done", trace[trace.size()-1].instr_done, 1'b1);
        check("illegal_halted_low", trace[trace.size()-1].halted, 1'b0);
        run_instr(6'h00, 6'h01, 1'b0, 1, 0);
        build_expect(6'h00, 6'h01, 1'b0, 1, 0);
        compare_trace("illegal_funct");
`endif

        // Reset in the middle of a stalled sw.
        @(negedge clk);
        opcode = 6'h2B; funct = 6'h00; mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw_stall_req", mem_bus.mem_req, 1'b1);
        check("sw_stall_we", mem_bus.mem_we, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreq_reset_outputs", 32'(sample()), 32'd0);
        check("midreq_reset_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        s = sample();
        check("after_reset_req", s.mem_req, 1'b1);
        check("after_reset_iord", s.iord, 1'b0);
        check("after_reset_we", s.mem_we, 1'b0);
        check("after_reset_instret", instret, 32'd0);
        model_instret = 32'd0;

        // Random instruction stream with random wait states.
        for (int n = 0; n < 150; n++) begin
            int pick;
            pick = $urandom_range(0, 19);
            rop = tbl[pick].op;
            rfn = (rop == 6'h00) ? tbl[pick].fn : 6'($urandom);
            rzr = 1'($urandom);
`ifndef KY32_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                rop = 6'($urandom_range(16, 34));
                rfn = 6'($urandom);
            end
`endif
            build_expect(rop, rfn, rzr, $urandom_range(0, 3), $urandom_range(0, 3));
            begin
                int wf, wm;
                wf = 0; wm = 0;
                foreach (exp_q[i]) begin
                    if (exp_q[i].mem_req && !exp_q[i].iord && !exp_q[i].ir_we) wf++;
                    if (exp_q[i].mem_req && exp_q[i].iord && !(exp_q[i].instr_done ||
                        (i + 1 < exp_q.size() && exp_q[i+1].mem_to_reg))) wm++;
                end
                run_instr(rop, rfn, rzr, wf, wm);
            end
            compare_trace($sformatf("rand%0d", n));
        end

        @(negedge clk);
        check("final_instret", instret, model_instret);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ky32_ctrl.md
Name: ky32_ctrl

Overview:
Multi-cycle main control FSM for the KY32 core. It fetches and decodes each instruction, then sequences the datapath through execute, memory and writeback steps. It drives the 4-bit ALU operation code and the operand selects, and consumes the ALU zero flag for branches. It handshakes with a single shared instruction/data memory port.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); fixed, not for override.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], from the instruction register
- funct  input  6  IR[5:0]
- alu_zr  input  1  ALU zero flag
- mem_ready  input  1  memory completes the request this cycle
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  write qualifier for mem_req
- iord  output  1  0 = address from PC, 1 = address from ALUOut
- ir_we  output  1  load the instruction register
- pc_we  output  1  load the PC
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
- alu_srca  output  1  0 = PC, 1 = reg A
- alu_srcb  output  2  00 reg B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2
- imm_zx  output  1  1 = zero-extend imm16, 0 = sign-extend
- alu_c  output  4  ALU op code
- reg_we  output  1  register-file write
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  writeback from MDR
- instr_done  output  1  one-cycle pulse when an instruction retires
- instret  output  32  retired-instruction counter
- halted  output  1  see Optional Feature

Behaviour:
- ALU codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- Shift amount comes from A[4:0]; value shifted is B.
- State register: 4 bits. States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, HALT 10.
- Outputs are Moore, decoded from state. pc_we and ir_we in FETCH, and step advance in MEMRD/MEMWR, are qualified by mem_ready.
- While rst_n=0: state=FETCH, instret=0, and all outputs are forced to 0.
- FETCH: mem_req=1, iord=0, srca=0, srcb=01, alu_c=ADD, pc_src=00.
  - If mem_ready: ir_we=1, pc_we=1, go to DECODE.
  - Otherwise stay in FETCH with no strobes.
- DECODE: srca=0, srcb=11, alu_c=ADD, which precomputes the branch target into ALUOut. Next state by opcode:
  - 0x23/0x2B go to MEMADR.
  - 0x00 with legal funct, or 0x08/0x0C/0x0D/0x0E/0x0F, go to EXEC.
  - 0x04/0x05 go to BRANCH.
  - 0x02 goes to JUMP.
  - Anything else is illegal.
- MEMADR: srca=1, srcb=10, imm_zx=0, ADD. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1; wait for mem_ready, then go to MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1; retire.
- MEMWR: mem_req=1, mem_we=1, iord=1; retire on mem_ready.
- EXEC, R-type: srca=1, srcb=00.
  - funct 20 ADD, 22 SUB, 24 AND, 25 OR, 26 XOR.
  - funct 00/02/03 give SLL/SRL/SRA with srca=1 (A = rs).
- EXEC, I-type: srca=1, srcb=10.
  - addi: ADD, imm_zx=0.
  - andi/ori/xori: AND/OR/XOR, imm_zx=1.
  - lui: LUI.
- EXEC always goes to ALUWB.
- ALUWB: reg_we=1, mem_to_reg=0, reg_dst=1 for R-type, 0 for I-type; retire.
- BRANCH: srca=1, srcb=00, SUB, pc_src=01.
  - pc_we = (beq & alu_zr) | (bne & ~alu_zr).
  - Retire.
- JUMP: pc_we=1, pc_src=10; retire.
- Retire means: go to FETCH next cycle, instr_done=1 for one cycle, instret += 1 (wraps 0xFFFFFFFF to 0).
- mem_ready is ignored in states without mem_req.
- mem_req never deasserts before mem_ready.
- Reset mid-request drops mem_req immediately; the next request starts from FETCH.

Optional Feature:
- Macro KY32_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode/funct in DECODE goes to HALT. HALT drives halted=1 and all strobes 0, stays there until reset, and does not count.
- Undefined: an illegal instruction goes from DECODE to FETCH as a NOP. instr_done pulses and instret increments; halted is tied to 0.

Test Plan:
- Reset, then mem_ready=1 with IR = add (op 00, funct 20) -> states FETCH, DECODE, EXEC (alu_c=0000, srcb=00), ALUWB (reg_we=1, reg_dst=1); instret=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEMRD -> mem_req=1, iord=1 held 4 cycles; MEMWB mem_to_reg=1; 5 states total plus 3 wait cycles.
- beq with alu_zr=1 -> pc_we=1, pc_src=01; bne with alu_zr=1 -> pc_we=0; both retire.
- ori and lui -> alu_c=0101 with imm_zx=1; alu_c=0110; sra (funct 03) -> alu_c=1111.
- Opcode 0x3F -> with KY32_ILLEGAL_TRAP_EN, HALT with halted=1 and no mem_req; without it, FETCH next and instret increments.
- rst_n asserted in MEMWR mid-wait -> all outputs 0 at once; after release FETCH with mem_req=1 and instret=0.
